// File: rtl/ff_pipe_skid.sv
// rtl/ff_pipe_skid.sv - cascade of two-entry skid stages with registered upstream ready,
// synchronous flush and a combinational occupancy count.
module ff_pipe_skid #(
    parameter int DATA_W = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = $clog2(2 * STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    logic [STAGES-1:0] r_main_v;
    logic [STAGES-1:0] r_skid_v;
    logic [DATA_W-1:0] r_main_d [STAGES];
    logic [DATA_W-1:0] r_skid_d [STAGES];

    logic [STAGES-1:0] w_up_valid;
    logic [STAGES-1:0] w_dn_ready;
    logic [DATA_W-1:0] w_up_data [STAGES];
    logic [CNT_W-1:0]  w_count;

    // Stage k is fed by stage k-1's main register; its ready is the next stage's !skid_v.
    always_comb begin
        w_up_valid = '0;
        w_dn_ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_up_data[k] = '0;
        end
        w_up_valid[0] = in_valid;
        w_up_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            w_up_valid[k] = r_main_v[k-1];
            w_up_data[k]  = r_main_d[k-1];
        end
        for (int k = 0; k < STAGES - 1; k++) begin
            w_dn_ready[k] = !r_skid_v[k+1];
        end
        w_dn_ready[STAGES-1] = out_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_v <= '0;
            r_skid_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_main_d[k] <= '0;
                r_skid_d[k] <= '0;
            end
        end else if (flush) begin
            r_main_v <= '0;
            r_skid_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (r_skid_v[k] && w_dn_ready[k]) begin
                    r_main_d[k] <= r_skid_d[k];
                    r_skid_v[k] <= 1'b0;
                end else if (w_up_valid[k] && !r_skid_v[k]) begin
                    // Park the word in the skid only when main is stuck behind backpressure.
                    if (!r_main_v[k] || w_dn_ready[k]) begin
                        r_main_d[k] <= w_up_data[k];
                        r_main_v[k] <= 1'b1;
                    end else begin
                        r_skid_d[k] <= w_up_data[k];
                        r_skid_v[k] <= 1'b1;
                    end
                end else if (r_main_v[k] && w_dn_ready[k]) begin
                    r_main_v[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_count = w_count + CNT_W'(r_main_v[k]) + CNT_W'(r_skid_v[k]);
        end
    end

    assign in_ready  = !r_skid_v[0] && !flush;
    assign out_valid = r_main_v[STAGES-1];
    assign out_data  = r_main_d[STAGES-1];
    assign count     = w_count;

endmodule
